// File: rtl/exe_muldiv.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers for the EXE stage.
// The result is computed at issue and parked in a pending pair until the busy window expires.
module exe_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_we_q, pend_we_d;

  logic               issue;
  logic               is_div, is_signed, b_zero;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        abs_a, abs_b, uq, ur, quo, rem;
  logic [31:0]        res_hi, res_lo;

  assign issue     = (state_q == IDLE) && start && !op[2];
  assign is_div    = op[1];
  assign is_signed = !op[0];
  assign b_zero    = (b == 32'd0);

  // Signed product taken mod 2^64 from sign-extended operands.
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  assign abs_a = (is_signed && a[31]) ? -a : a;
  assign abs_b = (is_signed && b[31]) ? -b : b;
  assign uq    = b_zero ? 32'd0 : abs_a / abs_b;
  assign ur    = b_zero ? 32'd0 : abs_a % abs_b;
  assign quo   = (is_signed && (a[31] ^ b[31])) ? -uq : uq;
  assign rem   = (is_signed && a[31]) ? -ur : ur;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else if (is_signed) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_we_d = !(is_div && b_zero);
        end else if (start && op == 3'd4) begin
          hi_d = a;
        end else if (start && op == 3'd5) begin
          lo_d = a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1) && pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign stall_req = busy | (start & (op <= 3'd3));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: busy-window lengths, HI/LO results, MTHI/MTLO, abort and back-to-back issue.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  exe_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds start for one edge and returns at the following negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    chk({tag, "_stall_req"}, {31'd0, stall_req}, {31'd0, (o <= 3'd3)});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles seen at negedges; bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    $display("MULT  -2*3            cycles=%0d hi=%h lo=%h", n, hi, lo);

    // MULTU max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    $display("MULTU max*max         cycles=%0d hi=%h lo=%h", n, hi, lo);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    $display("DIV   -7/2            cycles=%0d hi=%h lo=%h", n, hi, lo);

    // DIVU 7 / 0 leaves HI/LO alone
    issue(3'd3, 32'd7, 32'd0, "divu0");
    wait_idle(n);
    chk("divu0_cycles", n, 32'd10);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    $display("DIVU  7/0             cycles=%0d hi=%h lo=%h", n, hi, lo);

    // MTHI / MTLO
    issue(3'd4, 32'h0000_1234, 32'd0, "mthi");
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);
    issue(3'd5, 32'h0000_5678, 32'd0, "mtlo");
    chk("mtlo_lo", lo, 32'h0000_5678);
    chk("mtlo_hi", hi, 32'h0000_1234);
    $display("MTHI/MTLO             hi=%h lo=%h", hi, lo);

    // op 6 is a no-op
    issue(3'd6, 32'hDEAD_BEEF, 32'd1, "nop");
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h0000_1234);
    chk("nop_lo", lo, 32'h0000_5678);
    $display("NOP   op=6            hi=%h lo=%h", hi, lo);

    // DIV overflow corner
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    wait_idle(n);
    chk("divovf_cycles", n, 32'd10);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);
    $display("DIV   min/-1          cycles=%0d hi=%h lo=%h", n, hi, lo);

    // DIVU 100 / 7
    issue(3'd3, 32'd100, 32'd7, "divu");
    wait_idle(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    $display("DIVU  100/7           cycles=%0d hi=%h lo=%h", n, hi, lo);

    // Start while busy is ignored; later operand changes do not matter
    issue(3'd0, 32'd6, 32'd7, "ign");
    chk("ign_stall_busy", {31'd0, stall_req}, 32'd1);
    start = 1'b1; op = 3'd1; a = 32'd1000; b = 32'd1000;
    wait_idle(n);
    chk("ign_cycles", n, 32'd5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);
    $display("MULT  6*7 + ignored   cycles=%0d hi=%h lo=%h", n, hi, lo);

    // Reset in the third busy cycle of a DIV aborts it
    issue(3'd3, 32'd100, 32'd7, "abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);
    $display("DIVU  aborted         hi=%h lo=%h", hi, lo);

    // Back-to-back MULTs
    issue(3'd0, 32'd3, 32'd4, "b2b1");
    wait_idle(n);
    chk("b2b1_cycles", n, 32'd5);
    chk("b2b1_lo", lo, 32'd12);
    issue(3'd0, 32'hFFFF_FFFB, 32'd6, "b2b2");
    chk("b2b2_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b2_cycles", n, 32'd5);
    chk("b2b2_hi", hi, 32'hFFFF_FFFF);
    chk("b2b2_lo", lo, 32'hFFFF_FFE2);
    $display("MULT  b2b -5*6        cycles=%0d hi=%h lo=%h", n, hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
